wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Writeback arbiter that merges results from the single-cycle ALU, the load/store unit (LSU) and the multi-cycle mul/div unit (MDU) onto the register file's single write port (`rd`, `result`, `reg_write`). It is the producer side of that port and drives it from registers. It also keeps a per-register pending-write scoreboard that decode uses to stall on in-flight long-latency destinations. It sits between the execute-side units and the register file.

## Interface
Parameters:
- `XLEN`, 32: data width.
- `NREG`, 32: number of architectural registers; the index width is log2(`NREG`) = 5.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `alu_valid`  in  1  ALU result present. There is no ready; the ALU is always accepted.
- `alu_rd`  in  5  ALU destination.
- `alu_result`  in  XLEN  ALU data.
- `lsu_valid`  in  1  load result present.
- `lsu_ready`  out  1  load result accepted this cycle. Combinational.
- `lsu_rd`  in  5  load destination.
- `lsu_data`  in  XLEN  load data.
- `mdu_valid`  in  1  mul/div result present.
- `mdu_ready`  out  1  mul/div result accepted this cycle. Combinational.
- `mdu_rd`  in  5  mul/div destination.
- `mdu_result`  in  XLEN  mul/div data.
- `issue_valid`  in  1  decode issued a long-latency op (load or mul/div).
- `issue_rd`  in  5  destination of that op.
- `busy`  out  NREG  pending-write bit per register. Registered.
- `rd`  out  5  register file write index. Registered.
- `result`  out  XLEN  register file write data. Registered.
- `reg_write`  out  1  register file write enable. Registered.

## Operation
- Acceptance is a fixed-then-fair priority:
  - ALU has absolute priority.
  - When `alu_valid`=0, LSU and MDU share the port by round-robin. Pointer `rr_lsu`=1 means LSU is preferred.
- Ready equations:
  - `lsu_ready` = !`alu_valid` & `lsu_valid` & (`rr_lsu` | !`mdu_valid`).
  - `mdu_ready` = !`alu_valid` & `mdu_valid` & (!`rr_lsu` | !`lsu_valid`).
  - At most one ready is high per cycle.
- Pointer update:
  - On LSU accept, `rr_lsu`←0.
  - On MDU accept, `rr_lsu`←1.
  - Otherwise it holds.
- Source data stability: LSU/MDU hold `valid`/`rd`/data stable until they see `ready`.
- Accepted source: its rd/data are registered into `rd`/`result`.
  - `reg_write`←1 if the accepted rd≠0, else 0. A write to x0 is consumed and dropped.
- No source accepted: `reg_write`←0. `rd`/`result` hold their last values.
- Scoreboard, next-state per register i:
  - `busy[i]` is set when `issue_valid` & `issue_rd`==i & i≠0.
  - `busy[i]` is cleared when an LSU/MDU accept targets i.
  - If set and clear hit the same register in the same cycle, set wins (a newer op is pending).
  - ALU accepts never clear busy.
  - `busy[0]` is constant 0.
- Reset values: `rd`=0, `result`=0, `reg_write`=0, `busy`=0, `rr_lsu`=1.
- Reset mid-operation:
  - An in-flight writeback is discarded (`reg_write`=0 the next cycle).
  - Ready outputs are forced to 0 while `rst`=1.

## Timing
- Accept in cycle N → `reg_write`=1 with that rd/data in cycle N+1. The register file commits at the end of N+1 and bypasses `result` combinationally during N+1.
- Throughput: one write per cycle. Back-to-back accepts give back-to-back `reg_write`.
- Busy clear is visible in cycle N+1, aligned with `reg_write`, so decode stall release and the register-file bypass coincide.
- Issue in cycle N → `busy` set in N+1.
- Starvation bound: with the ALU idle, a waiting LSU or MDU is accepted within 2 cycles. Under continuous `alu_valid`, both stall indefinitely; this is by design, and the issue logic guarantees ALU bubbles.

## Configuration
- `WB_SCOREBOARD_EN` defined: scoreboard implemented as above.
- `WB_SCOREBOARD_EN` undefined:
  - `busy` is tied to 0.
  - `issue_valid`/`issue_rd` are ignored.
  - Decode must then use its own in-order stall.

## Structure
- Shared package `cpu_pkg` holds:
  - `XLEN`, `NREG` and the register-index width.
  - The writeback source enum (`WB_SRC_ALU`, `WB_SRC_LSU`, `WB_SRC_MDU`).
  - A `wb_req_t` {valid, rd, data} typedef.
- One natural sub-module: `wb_scoreboard` (busy vector, set/clear logic, x0 masking). It is instantiated only under `WB_SCOREBOARD_EN`.

## Test plan
- Reset, then `alu_valid`=1, `alu_rd`=5, `alu_result`=0xDEADBEEF → next cycle `reg_write`=1, `rd`=5, `result`=0xDEADBEEF.
- `alu_valid`=1 with `lsu_valid`=1 and `mdu_valid`=1 → `lsu_ready`=`mdu_ready`=0; the ALU is written. Drop `alu_valid` → LSU accepted first (`rr_lsu`=1 after reset), MDU the following cycle.
- LSU and MDU continuously valid, ALU idle, 6 cycles → accepts alternate LSU, MDU, LSU, MDU, LSU, MDU; `reg_write`=1 on all 6 following cycles.
- `issue_valid`=1, `issue_rd`=7 → `busy[7]`=1 next cycle. MDU writes rd=7 in the same cycle as a new issue to rd=7 → `busy[7]` stays 1. A later MDU write to rd=7 with no new issue → `busy[7]`=0.
- LSU write with `lsu_rd`=0, data 0x1234 → `lsu_ready`=1, next cycle `reg_write`=0. Issue to x0 → `busy[0]` stays 0.
- `rst` asserted in the cycle after an MDU accept → `reg_write`=0, `busy`=0, both readies 0 during reset.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared CPU constants and writeback types: data width,
//                register count and index width, writeback source encoding
//                and the {valid, rd, data} writeback request bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int RIDX_W = $clog2(NREG);

    typedef enum logic [1:0] {
        WB_SRC_ALU = 2'd0,
        WB_SRC_LSU = 2'd1,
        WB_SRC_MDU = 2'd2
    } wb_src_e;

    typedef struct packed {
        logic              valid;
        logic [RIDX_W-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

    function automatic wb_req_t mk_req(input logic              valid,
                                       input logic [RIDX_W-1:0] rd,
                                       input logic [XLEN-1:0]   data);
        wb_req_t req;
        req.valid = valid;
        req.rd    = rd;
        req.data  = data;
        return req;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arbiter_if
//  Description : Writeback bus between the execute units / decode (master)
//                and the writeback arbiter (slave).
//  Ports       : master drives ALU/LSU/MDU results and decode issue info;
//                slave drives lsu_ready, mdu_ready, busy and the register
//                file write port (rd, result, reg_write).
//  Revision    : 1.0 - initial release
// ============================================================================
interface wb_arbiter_if #(
    parameter int XLEN = cpu_pkg::XLEN,
    parameter int NREG = cpu_pkg::NREG
);
    localparam int C_RIDX_W = $clog2(NREG);

    logic                alu_valid;
    logic [C_RIDX_W-1:0] alu_rd;
    logic [XLEN-1:0]     alu_result;
    logic                lsu_valid;
    logic                lsu_ready;
    logic [C_RIDX_W-1:0] lsu_rd;
    logic [XLEN-1:0]     lsu_data;
    logic                mdu_valid;
    logic                mdu_ready;
    logic [C_RIDX_W-1:0] mdu_rd;
    logic [XLEN-1:0]     mdu_result;
    logic                issue_valid;
    logic [C_RIDX_W-1:0] issue_rd;
    logic [NREG-1:0]     busy;
    logic [C_RIDX_W-1:0] rd;
    logic [XLEN-1:0]     result;
    logic                reg_write;

    modport master (
        output alu_valid, alu_rd, alu_result,
        output lsu_valid, lsu_rd, lsu_data,
        output mdu_valid, mdu_rd, mdu_result,
        output issue_valid, issue_rd,
        input  lsu_ready, mdu_ready, busy, rd, result, reg_write
    );

    modport slave (
        input  alu_valid, alu_rd, alu_result,
        input  lsu_valid, lsu_rd, lsu_data,
        input  mdu_valid, mdu_rd, mdu_result,
        input  issue_valid, issue_rd,
        output lsu_ready, mdu_ready, busy, rd, result, reg_write
    );

endinterface
`default_nettype wire

// File: rtl/wb_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : wb_scoreboard
//  Description : Per-register pending-write vector for long-latency ops.
//                A bit is set one cycle after issue and cleared one cycle
//                after the LSU/MDU writeback to that register is accepted.
//                Set beats clear on the same register (a newer op is in
//                flight). Bit 0 (x0) is never set.
//  Ports       : clk, rst (sync, active high)
//                i_set_valid / i_set_rd : decode issue of a long-latency op
//                i_clr_valid / i_clr_rd : LSU/MDU writeback accepted
//                o_busy                 : registered pending-write vector
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_scoreboard #(
    parameter  int NREG     = cpu_pkg::NREG,
    localparam int C_RIDX_W = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_set_valid,
    input  logic [C_RIDX_W-1:0] i_set_rd,
    input  logic                i_clr_valid,
    input  logic [C_RIDX_W-1:0] i_clr_rd,
    output logic [NREG-1:0]     o_busy
);

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_nxt;

    // Clear applied first so a coincident set on the same index wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_clr_valid) begin
            w_busy_nxt[i_clr_rd] = 1'b0;
        end
        if (i_set_valid) begin
            w_busy_nxt[i_set_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign o_busy = r_busy;

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arbiter
//  Description : Merges ALU, LSU and MDU results onto the register file's
//                single registered write port. ALU has absolute priority;
//                with the ALU idle, LSU and MDU alternate by round-robin.
//                Writes to x0 are accepted and dropped.
//  Ports       : clk, rst (sync, active high)
//                bus (wb_arbiter_if.slave):
//                  alu_valid/alu_rd/alu_result     ALU result (always taken)
//                  lsu_valid/lsu_rd/lsu_data       load result, lsu_ready out
//                  mdu_valid/mdu_rd/mdu_result     mul/div result, mdu_ready out
//                  issue_valid/issue_rd            long-latency issue
//                  busy                            pending-write vector
//                  rd/result/reg_write             register file write port
//  Config      : WB_SCOREBOARD_EN - when defined, the pending-write
//                scoreboard is built; otherwise busy is tied to zero and the
//                issue inputs are ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter
    import cpu_pkg::*;
#(
    parameter  int XLEN     = cpu_pkg::XLEN,
    parameter  int NREG     = cpu_pkg::NREG,
    localparam int C_RIDX_W = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    wb_arbiter_if.slave   bus
);

    logic                r_rr_lsu;
    logic [C_RIDX_W-1:0] r_rd;
    logic [XLEN-1:0]     r_result;
    logic                r_reg_write;

    logic                w_lsu_ready;
    logic                w_mdu_ready;
    wb_src_e             w_src;
    wb_req_t             w_sel_req;
    logic [NREG-1:0]     w_busy;

    // Readies are forced low in reset so no source believes it was consumed.
    assign w_lsu_ready = ~rst & ~bus.alu_valid & bus.lsu_valid
                         & (r_rr_lsu | ~bus.mdu_valid);
    assign w_mdu_ready = ~rst & ~bus.alu_valid & bus.mdu_valid
                         & (~r_rr_lsu | ~bus.lsu_valid);

    // Source choice. MDU is the fall-through when ALU is idle; its request
    // is only valid when mdu_ready is high, so "nothing accepted" simply
    // shows up as an invalid MDU request.
    always_comb begin
        w_src = WB_SRC_ALU;
        if (!bus.alu_valid) begin
            w_src = w_lsu_ready ? WB_SRC_LSU : WB_SRC_MDU;
        end
    end

    always_comb begin
        w_sel_req = '0;
        case (w_src)
            WB_SRC_ALU: w_sel_req = mk_req(bus.alu_valid, bus.alu_rd, bus.alu_result);
            WB_SRC_LSU: w_sel_req = mk_req(w_lsu_ready,   bus.lsu_rd, bus.lsu_data);
            WB_SRC_MDU: w_sel_req = mk_req(w_mdu_ready,   bus.mdu_rd, bus.mdu_result);
            default:    w_sel_req = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd        <= '0;
            r_result    <= '0;
            r_reg_write <= 1'b0;
            r_rr_lsu    <= 1'b1;
        end else begin
            r_reg_write <= w_sel_req.valid & (w_sel_req.rd != '0);
            if (w_sel_req.valid) begin
                r_rd     <= w_sel_req.rd;
                r_result <= w_sel_req.data;
            end
            if (w_lsu_ready) begin
                r_rr_lsu <= 1'b0;
            end else if (w_mdu_ready) begin
                r_rr_lsu <= 1'b1;
            end
        end
    end

`ifdef WB_SCOREBOARD_EN
    // Only LSU/MDU accepts retire pending writes; ALU results never do.
    logic w_clr_valid;
    assign w_clr_valid = w_lsu_ready | w_mdu_ready;

    wb_scoreboard #(
        .NREG        (NREG)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .i_set_valid (bus.issue_valid),
        .i_set_rd    (bus.issue_rd),
        .i_clr_valid (w_clr_valid),
        .i_clr_rd    (w_sel_req.rd),
        .o_busy      (w_busy)
    );
`else
    logic w_unused_issue;
    assign w_unused_issue = ^{bus.issue_valid, bus.issue_rd};
    assign w_busy         = '0;
`endif

    assign bus.lsu_ready = w_lsu_ready;
    assign bus.mdu_ready = w_mdu_ready;
    assign bus.busy      = w_busy;
    assign bus.rd        = r_rd;
    assign bus.result    = r_result;
    assign bus.reg_write = r_reg_write;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_arbiter
//  Description : Directed testbench for wb_arbiter. Each stimulus step
//                queues the register-file write it should cause; a monitor
//                on the falling edge pops and compares writes and flags any
//                write that was not expected.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_arbiter_if #(.XLEN(32), .NREG(32)) bus ();

    wb_arbiter #(
        .XLEN (32),
        .NREG (32)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.slave)
    );

    typedef struct {
        int          due;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   errors  = 0;
    int   cyc     = 0;
    bit   mon_en  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor
    always @(negedge clk) begin
        if (mon_en) begin
            vectors++;
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                if (bus.reg_write !== 1'b1 || bus.rd !== e.rd || bus.result !== e.data) begin
                    errors++;
                    $display("FAIL wb_write cyc=%0d: got we=%b rd=%0d data=%h, expected we=1 rd=%0d data=%h",
                             cyc, bus.reg_write, bus.rd, bus.result, e.rd, e.data);
                end
            end else if (bus.reg_write !== 1'b0) begin
                errors++;
                $display("FAIL wb_idle cyc=%0d: got we=%b rd=%0d, expected we=0",
                         cyc, bus.reg_write, bus.rd);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] sb(input logic [31:0] v);
`ifdef WB_SCOREBOARD_EN
        return v;
`else
        return (v & 32'h0);
`endif
    endfunction

    // src: 0 none, 1 ALU, 2 LSU, 3 MDU
    task automatic step(input string nm,
                        input logic av, input logic [4:0] ar, input logic [31:0] ad,
                        input logic lv, input logic [4:0] lr, input logic [31:0] ld,
                        input logic mv, input logic [4:0] mr, input logic [31:0] md,
                        input logic iv, input logic [4:0] ir,
                        input logic xl, input logic xm, input int src);
        exp_t e;
        bus.alu_valid = av; bus.alu_rd = ar; bus.alu_result = ad;
        bus.lsu_valid = lv; bus.lsu_rd = lr; bus.lsu_data   = ld;
        bus.mdu_valid = mv; bus.mdu_rd = mr; bus.mdu_result = md;
        bus.issue_valid = iv; bus.issue_rd = ir;
        #1;
        chk({nm, " lsu_ready"}, {31'b0, bus.lsu_ready}, {31'b0, xl});
        chk({nm, " mdu_ready"}, {31'b0, bus.mdu_ready}, {31'b0, xm});
        e.due = cyc + 1; e.rd = 5'd0; e.data = 32'h0;
        case (src)
            1: begin e.rd = ar; e.data = ad; end
            2: begin e.rd = lr; e.data = ld; end
            3: begin e.rd = mr; e.data = md; end
            default: ;
        endcase
        if (src != 0 && e.rd != 5'd0) exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_result = 0;
        bus.lsu_valid = 0; bus.lsu_rd = 0; bus.lsu_data   = 0;
        bus.mdu_valid = 0; bus.mdu_rd = 0; bus.mdu_result = 0;
        bus.issue_valid = 0; bus.issue_rd = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset rd",        {27'b0, bus.rd},        32'h0);
        chk("reset result",    bus.result,             32'h0);
        chk("reset reg_write", {31'b0, bus.reg_write}, 32'h0);
        chk("reset busy",      bus.busy,               32'h0);
        rst    = 1'b0;
        mon_en = 1'b1;

        //    name          av ar  ad            lv lr  ld         mv mr  md         iv ir  xl xm src
        step("alu_basic",   1, 5,  32'hDEADBEEF, 0, 0,  0,         0, 0,  0,         0, 0,  0, 0, 1);
        step("alu_prio",    1, 3,  32'h11,       1, 8,  32'hAAAA,  1, 9,  32'hBBBB,  0, 0,  0, 0, 1);
        step("lsu_first",   0, 0,  0,            1, 8,  32'hAAAA,  1, 9,  32'hBBBB,  0, 0,  1, 0, 2);
        step("mdu_next",    0, 0,  0,            0, 0,  0,         1, 9,  32'hBBBB,  0, 0,  0, 1, 3);
        step("rr1",         0, 0,  0,            1, 10, 32'h100,   1, 11, 32'h200,   0, 0,  1, 0, 2);
        step("rr2",         0, 0,  0,            1, 12, 32'h101,   1, 11, 32'h200,   0, 0,  0, 1, 3);
        step("rr3",         0, 0,  0,            1, 12, 32'h101,   1, 13, 32'h201,   0, 0,  1, 0, 2);
        step("rr4",         0, 0,  0,            1, 14, 32'h102,   1, 13, 32'h201,   0, 0,  0, 1, 3);
        step("rr5",         0, 0,  0,            1, 14, 32'h102,   1, 15, 32'h202,   0, 0,  1, 0, 2);
        step("rr6",         0, 0,  0,            1, 16, 32'h103,   1, 15, 32'h202,   0, 0,  0, 1, 3);

        step("issue7",      0, 0,  0,            0, 0,  0,         0, 0,  0,         1, 7,  0, 0, 0);
        chk("busy7 set",    bus.busy, sb(32'h0000_0080));
        step("mdu7_reiss",  0, 0,  0,            0, 0,  0,         1, 7,  32'h777,   1, 7,  0, 1, 3);
        chk("busy7 set_wins", bus.busy, sb(32'h0000_0080));
        step("mdu7_clr",    0, 0,  0,            0, 0,  0,         1, 7,  32'h778,   0, 0,  0, 1, 3);
        chk("busy7 cleared", bus.busy, 32'h0);

        step("lsu_x0",      0, 0,  0,            1, 0,  32'h1234,  0, 0,  0,         1, 0,  1, 0, 2);
        chk("busy0 stays0", bus.busy, 32'h0);
        chk("x0 result",    bus.result, 32'h1234);

        step("issue20",     0, 0,  0,            0, 0,  0,         0, 0,  0,         1, 20, 0, 0, 0);
        chk("busy20 set",   bus.busy, sb(32'h0010_0000));
        step("alu20",       1, 20, 32'h55,       0, 0,  0,         0, 0,  0,         0, 0,  0, 0, 1);
        chk("busy20 alu_keeps", bus.busy, sb(32'h0010_0000));
        step("lsu20",       0, 0,  0,            1, 20, 32'h66,    0, 0,  0,         0, 0,  1, 0, 2);
        chk("busy20 lsu_clr", bus.busy, 32'h0);

        step("mdu4_pre_rst", 0, 0, 0,            0, 0,  0,         1, 4,  32'h44,    1, 25, 0, 1, 3);
        chk("busy25 set",   bus.busy, sb(32'h0200_0000));

        // Reset in the cycle after an MDU accept, with both sources waiting.
        rst = 1'b1;
        bus.mdu_valid = 1; bus.mdu_rd = 2; bus.mdu_result = 32'h2;
        bus.lsu_valid = 1; bus.lsu_rd = 1; bus.lsu_data   = 32'h1;
        bus.issue_valid = 0;
        #1;
        chk("rst lsu_ready", {31'b0, bus.lsu_ready}, 32'h0);
        chk("rst mdu_ready", {31'b0, bus.mdu_ready}, 32'h0);
        @(posedge clk);
        #1;
        chk("rst reg_write", {31'b0, bus.reg_write}, 32'h0);
        chk("rst busy",      bus.busy, 32'h0);
        chk("rst rd",        {27'b0, bus.rd}, 32'h0);
        rst = 1'b0;

        step("post_rst_lsu", 0, 0, 0,            1, 1,  32'h1,     1, 2,  32'h2,     0, 0,  1, 0, 2);
        step("post_rst_mdu", 0, 0, 0,            0, 0,  0,         1, 2,  32'h2,     0, 0,  0, 1, 3);
        step("idle",         0, 0, 0,            0, 0,  0,         0, 0,  0,         0, 0,  0, 0, 0);
        repeat (3) @(posedge clk);
        #1;

        vectors++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d writes never seen, expected 0", exp_q.size());
        end
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
